// File: rtl/add_round_const_pkg.sv
// Shared geometry, round-constant LFSR parameters and FSM state type
// for the iota stage of the cell-serial Keccak-f round.
package add_round_const_pkg;

   localparam int NUM_ROW     = 5;
   localparam int NUM_COLUMN  = 5;
   localparam int NUM_PAGE    = 64;
   localparam int NUM_CELLS   = NUM_ROW * NUM_COLUMN * NUM_PAGE;
   localparam int LANE_STRIDE = NUM_ROW * NUM_COLUMN;

   localparam logic [7:0] RC_POLY      = 8'h71;
   localparam logic [7:0] RC_LFSR_INIT = 8'h01;
   localparam int         NUM_RC_BITS  = 7;

   localparam int SKIP_W = 8;
   localparam int JCNT_W = 3;
   localparam int LANE_W = $clog2(NUM_PAGE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SKIP  = 2'd1,
      ST_APPLY = 2'd2,
      ST_DONE  = 2'd3
   } arc_state_e;

endpackage

// File: rtl/add_round_const_lfsr.sv
// Keccak rc(t) generator: 8-bit Galois LFSR over x^8+x^6+x^5+x^4+1,
// current output bit is r[0].
module add_round_const_lfsr
   import add_round_const_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic step,
   output logic rc_bit
);

   logic [7:0] r_q;
   logic [7:0] r_d;

   always_comb begin
      r_d = r_q;
      if (load) begin
         r_d = RC_LFSR_INIT;
      end else if (step) begin
         r_d = {r_q[6:0], 1'b0} ^ (r_q[7] ? RC_POLY : 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= RC_LFSR_INIT;
      end else begin
         r_q <= r_d;
      end
   end

   assign rc_bit = r_q[0];

endmodule

// File: rtl/add_round_const.sv
// Iota stage: skips the LFSR ahead by 7*round steps, then XORs the seven
// live round-constant bits into lane (0,0) of the captured state.
module add_round_const
   import add_round_const_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4:0]           round,
   input  logic [NUM_CELLS-1:0] data_in,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_CELLS-1:0] data_out
);

   arc_state_e           state_q, state_d;
   logic [NUM_CELLS-1:0] data_q, data_d;
   logic [SKIP_W-1:0]    skip_cnt_q, skip_cnt_d;
   logic [JCNT_W-1:0]    jcnt_q, jcnt_d;

   logic                 lfsr_load;
   logic                 lfsr_step;
   logic                 rc_bit;
   logic [LANE_W:0]      lane_z;
   logic [NUM_PAGE-1:0]  lane_flip;
   logic [NUM_CELLS-1:0] cell_flip;

   add_round_const_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load   (lfsr_load),
      .step   (lfsr_step),
      .rc_bit (rc_bit)
   );

   // RC bit position 2^jcnt-1 within the lane; one extra bit so 63 fits.
   assign lane_z = (LANE_W+1)'((LANE_W+1)'(1) << jcnt_q) - (LANE_W+1)'(1);

   always_comb begin
      lane_flip = '0;
      if (state_q == ST_APPLY && lane_z < (LANE_W+1)'(NUM_PAGE)) begin
         lane_flip[lane_z[LANE_W-1:0]] = rc_bit;
      end
   end

   // Spread lane (0,0) bit z to cell index z*LANE_STRIDE.
   for (genvar gi = 0; gi < NUM_PAGE; gi++) begin : g_spread
      assign cell_flip[gi*LANE_STRIDE +: LANE_STRIDE] =
         {{(LANE_STRIDE-1){1'b0}}, lane_flip[gi]};
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      skip_cnt_d = skip_cnt_q;
      jcnt_d     = jcnt_q;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               data_d     = data_in;
               skip_cnt_d = 8'd7 * {3'b000, round};
               jcnt_d     = '0;
               lfsr_load  = 1'b1;
               state_d    = (round != 5'd0) ? ST_SKIP : ST_APPLY;
            end
         end
         ST_SKIP: begin
            lfsr_step  = 1'b1;
            skip_cnt_d = skip_cnt_q - 8'd1;
            if (skip_cnt_q <= 8'd1) begin
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            lfsr_step = 1'b1;
            data_d    = data_q ^ cell_flip;
            jcnt_d    = jcnt_q + 3'd1;
            if (jcnt_q == 3'(NUM_RC_BITS - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         skip_cnt_q <= '0;
         jcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         skip_cnt_q <= skip_cnt_d;
         jcnt_q     <= jcnt_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign data_out = data_q;

endmodule

// File: tb/tb_add_round_const.sv
// Directed bench for add_round_const: latency, lane (0,0) round constants,
// start filtering while busy, and reset during an operation.
module tb_add_round_const;
   import add_round_const_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [4:0]           round;
   logic [NUM_CELLS-1:0] data_in;
   logic                 busy;
   logic                 done;
   logic [NUM_CELLS-1:0] data_out;

   int n_assert = 0;
   int n_fail   = 0;

   add_round_const dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .round    (round),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [NUM_CELLS-1:0] lane_rc(input logic [63:0] rc);
      logic [NUM_CELLS-1:0] v;
      v = '0;
      for (int z = 0; z < 64; z++) v[z*25] = rc[z];
      return v;
   endfunction

   function automatic logic [63:0] lane_of(input logic [NUM_CELLS-1:0] s);
      logic [63:0] v;
      for (int z = 0; z < 64; z++) v[z] = s[z*25];
      return v;
   endfunction

   function automatic logic [NUM_CELLS-1:0] rand_state();
      logic [NUM_CELLS-1:0] v;
      for (int i = 0; i < NUM_CELLS/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [NUM_CELLS-1:0] act,
                           input logic [NUM_CELLS-1:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: lane00 got %h expected %h, %0d bits differ",
                tag, lane_of(act), lane_of(exp), $countones(act ^ exp));
      end
   endtask

   // Counts edges until done is seen; 0 reported on timeout.
   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         @(posedge clk); #1;
         n++;
         seen = (done === 1'b1);
      end
      chk_val({tag, "_latency"}, seen ? n : 0, exp_lat);
      chk_val({tag, "_busy_at_done"}, 32'(busy), 1);
   endtask

   task automatic run_op(input logic [4:0] r, input logic [NUM_CELLS-1:0] d,
                         input int exp_lat, input logic [NUM_CELLS-1:0] exp_data,
                         input string tag);
      @(negedge clk);
      start = 1'b1; round = r; data_in = d;
      @(posedge clk); #1;
      start = 1'b0;
      chk_val({tag, "_busy_rise"}, 32'(busy), 1);
      wait_done(tag, exp_lat);
      chk_data({tag, "_data"}, data_out, exp_data);
      @(posedge clk); #1;
      chk_val({tag, "_done_fall"}, 32'(done), 0);
      chk_val({tag, "_busy_fall"}, 32'(busy), 0);
      $display("op %s round=%0d lane00=%h", tag, r, lane_of(data_out));
   endtask

   initial begin
      logic [NUM_CELLS-1:0] ones;
      logic [NUM_CELLS-1:0] da, db, dc, dd;
      ones = '1;

      // Reset held with start asserted: reset must win.
      rst = 1'b0; start = 1'b1; round = 5'd0; data_in = ones;
      repeat (3) @(posedge clk);
      #1;
      chk_val("reset_busy", 32'(busy), 0);
      chk_val("reset_done", 32'(done), 0);
      chk_data("reset_data", data_out, '0);
      @(negedge clk);
      rst = 1'b1; start = 1'b0;

      run_op(5'd0, '0, 7, lane_rc(64'h1), "r0_zero");
      run_op(5'd1, '0, 14, lane_rc(64'h8082), "r1_zero");
      run_op(5'd23, ones, 168, ones ^ lane_rc(64'h8000000080008008), "r23_ones");
      da = rand_state();
      run_op(5'd2, da, 21, da ^ lane_rc(64'h800000000000808A), "r2_rand");

      // start pulsed mid-SKIP, then held high through DONE.
      da = rand_state(); db = rand_state(); dc = rand_state();
      @(negedge clk);
      start = 1'b1; round = 5'd1; data_in = da;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1; round = 5'd0; data_in = dc;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; round = 5'd0; data_in = db;
      wait_done("busy_start", 10);
      chk_data("busy_start_data", data_out, da ^ lane_rc(64'h8082));
      @(posedge clk); #1;
      chk_val("held_start_idle_busy", 32'(busy), 0);
      chk_data("held_start_hold", data_out, da ^ lane_rc(64'h8082));
      @(posedge clk); #1;
      start = 1'b0;
      chk_val("held_start_accept", 32'(busy), 1);
      wait_done("held_start", 7);
      chk_data("held_start_data", data_out, db ^ lane_rc(64'h1));
      $display("op held_start lane00=%h", lane_of(data_out));

      // Reset asserted in the middle of APPLY.
      dd = rand_state();
      @(negedge clk);
      start = 1'b1; round = 5'd0; data_in = dd;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_val("midrst_busy", 32'(busy), 0);
      chk_val("midrst_done", 32'(done), 0);
      chk_data("midrst_data", data_out, '0);
      @(negedge clk);
      rst = 1'b1;
      run_op(5'd0, dd, 7, dd ^ lane_rc(64'h1), "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
